inst_fetch: RTL

Instruction fetch unit: holds the program counter, issues one-at-a-time read requests to instruction memory over a req/ack + rvalid handshake, and presents fetched words to the IF/ID pipeline register on `if_pc`/`if_inst`. It is the producing end of the IF/ID interface. It also absorbs downstream stalls and branch/jump redirects (flush) without losing or duplicating instructions.

---
 rtl/inst_fetch_pkg.sv | 22 ++
 rtl/inst_fetch.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared constants, bus types and fetch FSM state encoding for inst_fetch.
package inst_fetch_pkg;

   localparam logic RST_ENABLE  = 1'b1;
   localparam int   INST_ADDR_W = 32;
   localparam int   INST_W      = 32;

   localparam logic [INST_W-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {
      IF_REQ  = 2'd0,
      IF_WAIT = 2'd1,
      IF_HOLD = 2'd2,
      IF_HALT = 2'd3
   } if_state_t;

   // Sequential fetch address; wraps modulo 2^32.
   function automatic logic [INST_ADDR_W-1:0] pc_next(input logic [INST_ADDR_W-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding imem read, word on if_* one cycle after rvalid; stall holds if_*,
// flush redirects and discards in-flight data. Macro IF_BUSERR_EN adds imem_rerr/if_excp and the HALT state.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   flush,
   input  logic [INST_ADDR_W-1:0] new_pc,
   output logic                   imem_req,
   output logic [INST_ADDR_W-1:0] imem_addr,
   input  logic                   imem_ack,
   input  logic                   imem_rvalid,
   input  logic [INST_W-1:0]      imem_rdata,
`ifdef IF_BUSERR_EN
   input  logic                   imem_rerr,
   output logic                   if_excp,
`endif
   output logic [INST_ADDR_W-1:0] if_pc,
   output logic [INST_W-1:0]      if_inst,
   output logic                   if_valid
);

   if_state_t              state, state_n;
   logic [INST_ADDR_W-1:0] pc, pc_n;
   logic                   kill, kill_n;
   logic [INST_ADDR_W-1:0] buf_pc, buf_pc_n;
   logic [INST_W-1:0]      buf_inst, buf_inst_n;
   logic                   ld;
   logic [INST_ADDR_W-1:0] ld_pc;
   logic [INST_W-1:0]      ld_inst;
   logic [INST_W-1:0]      rd_word;
`ifdef IF_BUSERR_EN
   logic                   buf_err, buf_err_n;
   logic                   ld_excp;

   assign rd_word = imem_rerr ? ZERO_WORD : imem_rdata;
`else
   assign rd_word = imem_rdata;
`endif

   // Gated by rst so the memory never sees a request while it is itself in reset.
   assign imem_req  = (state == IF_REQ) && (rst != RST_ENABLE);
   assign imem_addr = pc;

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      kill_n     = kill;
      buf_pc_n   = buf_pc;
      buf_inst_n = buf_inst;
      ld         = 1'b0;
      ld_pc      = pc;
      ld_inst    = buf_inst;
`ifdef IF_BUSERR_EN
      buf_err_n  = buf_err;
      ld_excp    = 1'b0;
`endif
      case (state)
         IF_REQ: begin
            if (flush) pc_n = new_pc;
            if (imem_ack) begin
               state_n = IF_WAIT;
               kill_n  = flush;
            end
         end
         IF_WAIT: begin
            if (imem_rvalid) begin
               state_n = IF_REQ;
               kill_n  = 1'b0;
               // A redirect always wins, even when the arriving word was already marked dead.
               if (flush) begin
                  pc_n = new_pc;
               end else if (!kill) begin
                  if (stall) begin
                     buf_pc_n   = pc;
                     buf_inst_n = rd_word;
                     state_n    = IF_HOLD;
`ifdef IF_BUSERR_EN
                     buf_err_n  = imem_rerr;
`endif
                  end else begin
                     ld      = 1'b1;
                     ld_pc   = pc;
                     ld_inst = rd_word;
                     pc_n    = pc_next(pc);
`ifdef IF_BUSERR_EN
                     ld_excp = imem_rerr;
                     if (imem_rerr) state_n = IF_HALT;
`endif
                  end
               end
            end else if (flush) begin
               pc_n   = new_pc;
               kill_n = 1'b1;
            end
         end
         IF_HOLD: begin
            if (flush) begin
               pc_n    = new_pc;
               state_n = IF_REQ;
            end else if (!stall) begin
               ld      = 1'b1;
               ld_pc   = buf_pc;
               ld_inst = buf_inst;
               pc_n    = pc_next(pc);
               state_n = IF_REQ;
`ifdef IF_BUSERR_EN
               ld_excp = buf_err;
               if (buf_err) state_n = IF_HALT;
`endif
            end
         end
         default: begin
            if (flush) begin
               pc_n    = new_pc;
               state_n = IF_REQ;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state    <= IF_REQ;
         pc       <= RESET_PC;
         kill     <= 1'b0;
         buf_pc   <= '0;
         buf_inst <= ZERO_WORD;
         if_pc    <= '0;
         if_inst  <= ZERO_WORD;
         if_valid <= 1'b0;
`ifdef IF_BUSERR_EN
         buf_err  <= 1'b0;
         if_excp  <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         kill     <= kill_n;
         buf_pc   <= buf_pc_n;
         buf_inst <= buf_inst_n;
`ifdef IF_BUSERR_EN
         buf_err  <= buf_err_n;
`endif
         if (ld) begin
            if_pc    <= ld_pc;
            if_inst  <= ld_inst;
            if_valid <= 1'b1;
`ifdef IF_BUSERR_EN
            if_excp  <= ld_excp;
`endif
         end else if (flush || !stall) begin
            // Bubble keeps if_pc so downstream still sees the last fetched address.
            if_inst  <= ZERO_WORD;
            if_valid <= 1'b0;
`ifdef IF_BUSERR_EN
            if_excp  <= 1'b0;
`endif
         end
      end
   end

endmodule
